// File: rtl/alu_issue_if.sv
// Command channel into the ALU issue block: valid/ready handshake carrying
// opcode, two operands and the destination register.
interface alu_issue_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_func;
  logic [15:0] cmd_a;
  logic [15:0] cmd_b;
  logic [2:0]  cmd_dst;

  modport master (output cmd_valid, cmd_func, cmd_a, cmd_b, cmd_dst, input cmd_ready);
  modport slave  (input cmd_valid, cmd_func, cmd_a, cmd_b, cmd_dst, output cmd_ready);
endinterface

// File: rtl/alu_issue.sv
// ALU issue stage: 2-entry command FIFO feeding an IDLE/ISSUE/WAIT/WB sequencer
// that fires the ALU, waits (with timeout) for its result and writes it back.
module alu_issue #(
  parameter int unsigned TIMEOUT = 7
) (
  input  logic         clk,
  input  logic         rst,
  alu_issue_if.slave   cmd,
  output logic         alu_en,
  output logic [2:0]   alu_func,
  output logic [15:0]  alu_a,
  output logic [15:0]  alu_b,
  input  logic         alu_done,
  input  logic [15:0]  alu_result,
  output logic         wb_en,
  output logic [2:0]   wb_addr,
  output logic [15:0]  wb_data,
  output logic         wb_zero,
  output logic         busy,
  output logic         err,
  output logic [7:0]   done_cnt
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, WB = 2'd3} state_t;

  typedef struct packed {
    logic [2:0]  func;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  dst;
  } entry_t;

  localparam logic [3:0] TIMEOUT_C = 4'(TIMEOUT);

  state_t      state_r, state_nxt_s;
  entry_t      fifo_r [2];
  entry_t      head_s, in_s;
  logic        wr_ptr_r, rd_ptr_r;
  logic [1:0]  count_r, count_nxt_s;
  logic        push_s, pop_s;
  logic        cmd_ready_r, cmd_ready_nxt_s;
  logic [2:0]  dst_r, dst_nxt_s;
  logic [3:0]  wait_cnt_r, wait_cnt_nxt_s;
  logic        alu_en_r, alu_en_nxt_s;
  logic [2:0]  alu_func_r, alu_func_nxt_s;
  logic [15:0] alu_a_r, alu_a_nxt_s, alu_b_r, alu_b_nxt_s;
  logic        wb_en_r, wb_en_nxt_s;
  logic [2:0]  wb_addr_r, wb_addr_nxt_s;
  logic [15:0] wb_data_r, wb_data_nxt_s;
  logic        wb_zero_r, wb_zero_nxt_s;
  logic        busy_r, busy_nxt_s;
  logic        err_r, err_nxt_s;
  logic [7:0]  done_cnt_r, done_cnt_nxt_s;

  // Sequencer next-state and registered-output values; loading the operand
  // registers happens on every entry into ISSUE.
  always_comb begin
    head_s         = fifo_r[rd_ptr_r];
    pop_s          = 1'b0;
    state_nxt_s    = state_r;
    dst_nxt_s      = dst_r;
    wait_cnt_nxt_s = wait_cnt_r;
    alu_en_nxt_s   = 1'b0;
    alu_func_nxt_s = alu_func_r;
    alu_a_nxt_s    = alu_a_r;
    alu_b_nxt_s    = alu_b_r;
    wb_en_nxt_s    = 1'b0;
    wb_addr_nxt_s  = wb_addr_r;
    wb_data_nxt_s  = wb_data_r;
    wb_zero_nxt_s  = wb_zero_r;
    err_nxt_s      = err_r;
    done_cnt_nxt_s = done_cnt_r;
    case (state_r)
      IDLE, WB: begin
        if (count_r != 2'd0) begin
          pop_s          = 1'b1;
          state_nxt_s    = ISSUE;
          alu_en_nxt_s   = 1'b1;
          alu_func_nxt_s = head_s.func;
          alu_a_nxt_s    = head_s.a;
          alu_b_nxt_s    = head_s.b;
          dst_nxt_s      = head_s.dst;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE: begin
        state_nxt_s    = WAIT;
        wait_cnt_nxt_s = 4'd1;
      end
      WAIT: begin
        if (alu_done) begin
          state_nxt_s    = WB;
          wb_en_nxt_s    = 1'b1;
          wb_addr_nxt_s  = dst_r;
          wb_data_nxt_s  = alu_result;
          wb_zero_nxt_s  = (alu_result == 16'h0000);
          done_cnt_nxt_s = done_cnt_r + 8'd1;
        end else if (wait_cnt_r == TIMEOUT_C) begin
          state_nxt_s = IDLE;
          err_nxt_s   = 1'b1;
        end else begin
          wait_cnt_nxt_s = wait_cnt_r + 4'd1;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // FIFO occupancy, ready and busy; a pop is credited to cmd_ready only one
  // cycle later, so ready never rises in the same cycle as the pop.
  always_comb begin
    push_s          = cmd.cmd_valid & cmd_ready_r;
    in_s            = {cmd.cmd_func, cmd.cmd_a, cmd.cmd_b, cmd.cmd_dst};
    count_nxt_s     = count_r + {1'b0, push_s} - {1'b0, pop_s};
    cmd_ready_nxt_s = ({1'b0, count_r} + {2'b00, push_s}) < 3'd2;
    busy_nxt_s      = (state_nxt_s != IDLE) || (count_nxt_s != 2'd0);
  end

  // State, FIFO and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= IDLE;
      fifo_r[0]   <= '0;
      fifo_r[1]   <= '0;
      wr_ptr_r    <= 1'b0;
      rd_ptr_r    <= 1'b0;
      count_r     <= 2'd0;
      cmd_ready_r <= 1'b0;
      dst_r       <= 3'd0;
      wait_cnt_r  <= 4'd0;
      alu_en_r    <= 1'b0;
      alu_func_r  <= 3'd0;
      alu_a_r     <= 16'h0000;
      alu_b_r     <= 16'h0000;
      wb_en_r     <= 1'b0;
      wb_addr_r   <= 3'd0;
      wb_data_r   <= 16'h0000;
      wb_zero_r   <= 1'b0;
      busy_r      <= 1'b0;
      err_r       <= 1'b0;
      done_cnt_r  <= 8'd0;
    end else begin
      if (push_s) begin
        fifo_r[wr_ptr_r] <= in_s;
        wr_ptr_r         <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      state_r     <= state_nxt_s;
      count_r     <= count_nxt_s;
      cmd_ready_r <= cmd_ready_nxt_s;
      dst_r       <= dst_nxt_s;
      wait_cnt_r  <= wait_cnt_nxt_s;
      alu_en_r    <= alu_en_nxt_s;
      alu_func_r  <= alu_func_nxt_s;
      alu_a_r     <= alu_a_nxt_s;
      alu_b_r     <= alu_b_nxt_s;
      wb_en_r     <= wb_en_nxt_s;
      wb_addr_r   <= wb_addr_nxt_s;
      wb_data_r   <= wb_data_nxt_s;
      wb_zero_r   <= wb_zero_nxt_s;
      busy_r      <= busy_nxt_s;
      err_r       <= err_nxt_s;
      done_cnt_r  <= done_cnt_nxt_s;
    end
  end

  assign cmd.cmd_ready = cmd_ready_r;
  assign alu_en        = alu_en_r;
  assign alu_func      = alu_func_r;
  assign alu_a         = alu_a_r;
  assign alu_b         = alu_b_r;
  assign wb_en         = wb_en_r;
  assign wb_addr       = wb_addr_r;
  assign wb_data       = wb_data_r;
  assign wb_zero       = wb_zero_r;
  assign busy          = busy_r;
  assign err           = err_r;
  assign done_cnt      = done_cnt_r;

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have parameter: TIMEOUT, 7, maximum cycles spent in WAIT before abort (range 2..15).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on posedge clk.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-low; sampled on posedge clk.
REQ-004 SHALL have port: cmd_valid  input  1  command offered.
REQ-005 SHALL have port: cmd_ready  output  1  command buffer can accept.
REQ-006 SHALL have ports: cmd_func  input  3, cmd_a  input  16, cmd_b  input  16, cmd_dst  input  3; ALU opcode, operands, destination register.
REQ-007 SHALL have ports: alu_en  output  1, alu_func  output  3, alu_a  output  16, alu_b  output  16; drive the ALU en_in/func/a/b.
REQ-008 SHALL have ports: alu_done  input  1, alu_result  input  16; connect to the ALU en_out/alu_out.
REQ-009 SHALL have ports: wb_en  output  1, wb_addr  output  3, wb_data  output  16, wb_zero  output  1; register-file writeback.
REQ-010 SHALL have ports: busy  output  1 (state != IDLE or buffer non-empty), err  output  1 (sticky timeout flag), done_cnt  output  8 (completed writebacks).

Function
REQ-011 SHALL buffer commands in a 2-entry FIFO of {func,a,b,dst}; push on posedge when cmd_valid & cmd_ready.
REQ-012 SHALL drive cmd_ready = (entry count < 2) from registered count; a pop in the same cycle does not raise cmd_ready early.
REQ-013 SHALL implement FSM states IDLE, ISSUE, WAIT, WB with registered outputs.
REQ-014 SHALL transition IDLE->ISSUE when FIFO non-empty, popping head into an operand register.
REQ-015 SHALL hold alu_en=1 for exactly one cycle in ISSUE, with alu_func/alu_a/alu_b from the operand register; ISSUE->WAIT unconditionally.
REQ-016 SHALL keep alu_en=0 in every other state, and alu_a/alu_b/alu_func stable until the next ISSUE.
REQ-017 SHALL in WAIT, on alu_done=1, capture alu_result into wb_data, set wb_zero=(alu_result==16'h0000), go to WB.
REQ-018 SHALL in WAIT count cycles from 1; if count reaches TIMEOUT without alu_done, set err=1, discard command, go to IDLE with no writeback.
REQ-019 SHALL assert wb_en for exactly one cycle in WB with wb_addr=cmd_dst of that command; increment done_cnt (wrap 255->0).
REQ-020 SHALL go WB->ISSUE directly if FIFO non-empty, else WB->IDLE.
REQ-021 SHALL yield latency: command accepted at edge E0 into empty idle block -> alu_en high E1..E2 -> wb_en high E3..E4.
REQ-022 SHALL ignore alu_done outside WAIT.
REQ-023 SHALL hold wb_data/wb_addr/wb_zero after WB until the next capture.
REQ-024 SHALL keep err set until reset; err does not stall further commands.

Reset
REQ-025 SHALL, on posedge clk with rst=0, clear FIFO, state=IDLE, cmd_ready=0, alu_en=0, alu_func=0, alu_a=0, alu_b=0, wb_en=0, wb_addr=0, wb_data=0, wb_zero=0, busy=0, err=0, done_cnt=0.
REQ-026 SHALL abort any in-flight command on reset mid-operation with no writeback; cmd_ready=1 first cycle after rst returns high.

Verification
REQ-027 SHALL cover: ADD func=001, a=16'h0003, b=16'h0004, dst=5 with ALU attached -> alu_en one cycle at E1, wb_en at E3, wb_addr=5, wb_data=16'h0007, wb_zero=0, done_cnt=1.
REQ-028 SHALL cover: SUB func=010, a=b=16'h1234 -> wb_data=16'h0000, wb_zero=1.
REQ-029 SHALL cover: three back-to-back cmd_valid cycles from reset -> first two accepted, cmd_ready=0 on third, all accepted commands written back in order, done_cnt=2 then third accepted later.
REQ-030 SHALL cover: alu_done tied 0, TIMEOUT=7 -> err=1 after 7 WAIT cycles, no wb_en, next command completes normally.
REQ-031 SHALL cover: rst=0 asserted during WAIT -> no wb_en, all outputs at reset values next cycle, done_cnt=0.
REQ-032 SHALL cover: done_cnt at 255 plus one completed command -> done_cnt=0.
